// File: rtl/core_io_pkg.sv
// Shared types and constants for the IN/OUT sequencer on the UART-Lite AXI4-Lite port.
// Holds the FSM state enum, the status register bit positions, the AXI OKAY code
// and the default UART register offsets.
package core_io_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STAT_AR,
    STAT_R,
    RX_AR,
    RX_R,
    TX_AWW,
    TX_B,
    RESP
  } io_state_t;

  // UART-Lite status register bits
  localparam int STAT_RX_VALID = 0;
  localparam int STAT_TX_FULL  = 3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Default register offsets
  localparam logic [3:0] DEF_RX_ADDR   = 4'h0;
  localparam logic [3:0] DEF_TX_ADDR   = 4'h4;
  localparam logic [3:0] DEF_STAT_ADDR = 4'h8;

endpackage

// File: rtl/core_io_ctrl.sv
// Purpose : sequences one core IN/OUT byte access at a time over AXI4-Lite to a UART-Lite:
//           poll status until RX data present / TX not full, then read RX or write TX.
// Latency : RSP_VALID 5 cycles after acceptance with a zero-wait slave; +2 cycles per extra poll.
// Backpr. : REQ_READY only in IDLE; BUSY stalls the core until the response cycle.
// Ports   : CLK/RST (async active-high); REQ_* request in, RSP_* one-cycle response out;
//           AR/R/AW/W/B AXI4-Lite master channels (4-bit offsets, 32-bit data).
module core_io_ctrl
  import core_io_pkg::*;
#(
  parameter int unsigned POLL_LIMIT = 0,
  parameter logic [3:0]  RX_ADDR    = DEF_RX_ADDR,
  parameter logic [3:0]  TX_ADDR    = DEF_TX_ADDR,
  parameter logic [3:0]  STAT_ADDR  = DEF_STAT_ADDR
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  input  logic        REQ_WRITE,
  input  logic [7:0]  REQ_WDATA,
  output logic        REQ_READY,
  output logic        RSP_VALID,
  output logic [7:0]  RSP_RDATA,
  output logic        RSP_ERR,
  output logic        BUSY,
  output logic [3:0]  ARADDR,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RVALID,
  output logic        RREADY,
  output logic [3:0]  AWADDR,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY
);

  localparam int unsigned PW = (POLL_LIMIT == 0) ? 1 : $clog2(POLL_LIMIT + 1);
  localparam logic [PW-1:0] LIMIT_V = PW'(POLL_LIMIT);

  io_state_t     state_q, state_d;
  logic          is_wr_q;
  logic [7:0]    byte_q;
  logic [PW-1:0] poll_q;
  logic [PW-1:0] poll_inc;
  logic          err_q;
  logic [7:0]    rdata_q;
  logic          aw_done_q, w_done_q;
  logic          aw_hs, w_hs;
  logic          stat_ok;
  logic          limit_hit;
  logic          unused_rdata;

  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID & WREADY;

  // Status says the pending access can proceed (RX has data for IN, TX has room for OUT)
  assign stat_ok = is_wr_q ? ~RDATA[STAT_TX_FULL] : RDATA[STAT_RX_VALID];

  // Saturating poll count; with POLL_LIMIT=0 it just sticks at its max and is never compared
  assign poll_inc  = (poll_q == {PW{1'b1}}) ? poll_q : poll_q + 1'b1;
  assign limit_hit = (POLL_LIMIT != 0) && (poll_inc == LIMIT_V);

  assign unused_rdata = ^RDATA[31:8];

  assign RSP_VALID = (state_q == RESP);
  assign RSP_ERR   = RSP_VALID & err_q;
  assign RSP_RDATA = (RSP_VALID && !err_q) ? rdata_q : 8'h00;
  assign BUSY      = (state_q != IDLE) && (state_q != RESP);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    REQ_READY = 1'b0;
    ARVALID   = 1'b0;
    ARADDR    = 4'h0;
    RREADY    = 1'b0;
    AWVALID   = 1'b0;
    AWADDR    = 4'h0;
    WVALID    = 1'b0;
    WDATA     = 32'h0;
    WSTRB     = 4'h0;
    BREADY    = 1'b0;
    case (state_q)
      IDLE: begin
        // Held low while reset is asserted so every output reads 0 during reset
        REQ_READY = ~RST;
        if (REQ_VALID) state_d = STAT_AR;
      end
      STAT_AR: begin
        ARVALID = 1'b1;
        ARADDR  = STAT_ADDR;
        if (ARREADY) state_d = STAT_R;
      end
      STAT_R: begin
        RREADY = 1'b1;
        if (RVALID) begin
          if (RRESP != RESP_OKAY)  state_d = RESP;
          else if (stat_ok)        state_d = is_wr_q ? TX_AWW : RX_AR;
          else if (limit_hit)      state_d = RESP;
          else                     state_d = STAT_AR;
        end
      end
      RX_AR: begin
        ARVALID = 1'b1;
        ARADDR  = RX_ADDR;
        if (ARREADY) state_d = RX_R;
      end
      RX_R: begin
        RREADY = 1'b1;
        if (RVALID) state_d = RESP;
      end
      TX_AWW: begin
        // AW and W are independent; each valid drops after its own handshake
        AWVALID = ~aw_done_q;
        WVALID  = ~w_done_q;
        AWADDR  = TX_ADDR;
        WDATA   = {24'h0, byte_q};
        WSTRB   = 4'b0001;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = TX_B;
      end
      TX_B: begin
        BREADY = 1'b1;
        if (BVALID) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      is_wr_q   <= 1'b0;
      byte_q    <= 8'h00;
      poll_q    <= '0;
      err_q     <= 1'b0;
      rdata_q   <= 8'h00;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (REQ_VALID) begin
            is_wr_q   <= REQ_WRITE;
            byte_q    <= REQ_WDATA;
            poll_q    <= '0;
            err_q     <= 1'b0;
            rdata_q   <= 8'h00;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end
        end
        STAT_R: begin
          if (RVALID) begin
            poll_q <= poll_inc;
            if ((RRESP != RESP_OKAY) || (!stat_ok && limit_hit)) err_q <= 1'b1;
          end
        end
        RX_R: begin
          if (RVALID) begin
            rdata_q <= RDATA[7:0];
            if (RRESP != RESP_OKAY) err_q <= 1'b1;
          end
        end
        TX_AWW: begin
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs)  w_done_q  <= 1'b1;
        end
        TX_B: begin
          if (BVALID && (BRESP != RESP_OKAY)) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_core_io_ctrl.sv
// Bench for core_io_ctrl: a small AXI4-Lite UART-Lite slave model driven on the falling edge,
// a response scoreboard (expected results queued at request time, popped on RSP_VALID),
// and one task per scenario.
module tb_core_io_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic        REQ_WRITE = 1'b0;
  logic [7:0]  REQ_WDATA = 8'h00;
  logic        REQ_READY;
  logic        RSP_VALID;
  logic [7:0]  RSP_RDATA;
  logic        RSP_ERR;
  logic        BUSY;
  logic [3:0]  ARADDR;
  logic        ARVALID;
  logic        ARREADY = 1'b0;
  logic [31:0] RDATA = 32'h0;
  logic [1:0]  RRESP = 2'b00;
  logic        RVALID = 1'b0;
  logic        RREADY;
  logic [3:0]  AWADDR;
  logic        AWVALID;
  logic        AWREADY = 1'b0;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY = 1'b0;
  logic [1:0]  BRESP = 2'b00;
  logic        BVALID = 1'b0;
  logic        BREADY;

  core_io_ctrl #(.POLL_LIMIT(4)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_WRITE(REQ_WRITE), .REQ_WDATA(REQ_WDATA), .REQ_READY(REQ_READY),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR), .BUSY(BUSY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       err;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  // Slave configuration (written by tasks only)
  logic [31:0] stat_seq [0:7];
  int          stat_len     = 0;
  int          st_base      = 0;
  logic [31:0] stat_default = 32'h0;
  logic [31:0] rx_data      = 32'h0;
  logic [1:0]  rx_resp      = 2'b00;
  logic [1:0]  b_resp       = 2'b00;
  int          aw_delay     = 0;
  bit          ar_ready_en  = 1'b1;

  // Slave state and observations (written by the slave process only)
  int          st_cnt = 0, rx_cnt = 0, ar_cnt = 0, b_cnt = 0;
  int          awv_cyc = 0, wv_cyc = 0, aw_wait = 0, idx = 0;
  logic [3:0]  ar_log[$];
  logic [3:0]  aw_addr_l = 4'h0;
  logic [31:0] wdata_l = 32'h0;
  logic [3:0]  wstrb_l = 4'h0;
  logic [3:0]  r_addr = 4'h0;
  bit          r_pend = 0, r_drop = 0, b_pend = 0, b_drop = 0, aw_got = 0, w_got = 0;

  // Slave: at each falling edge retire handshakes from the last rising edge, present new
  // R/B beats one cycle after the address handshake, and note handshakes due at the next edge.
  always @(negedge CLK) begin
    if (RST) begin
      RVALID = 1'b0; RDATA = 32'h0; RRESP = 2'b00;
      BVALID = 1'b0; BRESP = 2'b00;
      ARREADY = 1'b0; AWREADY = 1'b0; WREADY = 1'b0;
      r_pend = 0; r_drop = 0; b_pend = 0; b_drop = 0; aw_got = 0; w_got = 0; aw_wait = 0;
    end else begin
      if (r_drop) begin RVALID = 1'b0; RDATA = 32'h0; RRESP = 2'b00; r_drop = 0; end
      if (b_drop) begin BVALID = 1'b0; BRESP = 2'b00; b_drop = 0; end
      if (r_pend) begin
        RVALID = 1'b1;
        if (r_addr == 4'h8) begin
          idx   = st_cnt - st_base;
          RDATA = (idx >= 0 && idx < stat_len) ? stat_seq[idx[2:0]] : stat_default;
          RRESP = 2'b00;
          st_cnt++;
        end else begin
          RDATA = rx_data;
          RRESP = rx_resp;
          rx_cnt++;
        end
        r_pend = 0;
      end
      if (b_pend) begin BVALID = 1'b1; BRESP = b_resp; b_pend = 0; end
      if (AWVALID) begin
        AWREADY = (aw_wait >= aw_delay);
        aw_wait++;
        awv_cyc++;
      end else begin
        AWREADY = 1'b0;
        aw_wait = 0;
      end
      if (WVALID) wv_cyc++;
      WREADY  = 1'b1;
      ARREADY = ar_ready_en;
      if (ARVALID && ARREADY) begin ar_cnt++; ar_log.push_back(ARADDR); r_addr = ARADDR; r_pend = 1; end
      if (RVALID && RREADY) r_drop = 1;
      if (AWVALID && AWREADY) begin aw_got = 1; aw_addr_l = AWADDR; end
      if (WVALID && WREADY) begin w_got = 1; wdata_l = WDATA; wstrb_l = WSTRB; end
      if (aw_got && w_got) begin b_pend = 1; aw_got = 0; w_got = 0; end
      if (BVALID && BREADY) begin b_drop = 1; b_cnt++; end
    end
  end

  int acc_cnt = 0;
  int rsp_cnt = 0;
  always @(posedge CLK) begin
    if (REQ_VALID && REQ_READY) acc_cnt++;
    if (RSP_VALID) rsp_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Call at a falling edge with the DUT idle; returns one falling edge later.
  task automatic send_req(input logic wr, input logic [7:0] d);
    REQ_VALID = 1'b1; REQ_WRITE = wr; REQ_WDATA = d;
    @(negedge CLK);
    REQ_VALID = 1'b0;
  endtask

  // Waits (bounded) for RSP_VALID; lat counts cycles since acceptance.
  task automatic wait_rsp(output bit got, output int lat);
    lat = 1;
    while (!RSP_VALID && lat < 300) begin
      @(negedge CLK);
      lat++;
    end
    got = RSP_VALID;
  endtask

  task automatic test_reset();
    logic [59:0] v;
    @(negedge CLK);
    v = {ARVALID, ARADDR, RREADY, AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY,
         RSP_VALID, RSP_ERR, RSP_RDATA, BUSY};
    total++; if (v !== 60'h0) begin bad++; $display("FAIL reset_outs: got %h required 0", v); end
    total++; if (REQ_READY !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b required 1", REQ_READY); end
  endtask

  task automatic test_in();
    bit got; int lat; exp_t e; int ar0;
    stat_seq[0] = 32'h1; stat_len = 1; st_base = st_cnt;
    rx_data = 32'h41; rx_resp = 2'b00;
    ar0 = ar_cnt;
    exp_q.push_back('{1'b0, 8'h41});
    send_req(1'b0, 8'h00);
    wait_rsp(got, lat);
    e = exp_q.pop_front();
    total++; if (!got) begin bad++; $display("FAIL in_rsp: RSP_VALID not seen, required within bound"); end
    total++; if (lat !== 5) begin bad++; $display("FAIL in_latency: got %0d required 5", lat); end
    total++; if (RSP_RDATA !== e.data) begin bad++; $display("FAIL in_rdata: got %h required %h", RSP_RDATA, e.data); end
    total++; if (RSP_ERR !== e.err) begin bad++; $display("FAIL in_err: got %b required %b", RSP_ERR, e.err); end
    @(negedge CLK);
    total++; if (RSP_VALID !== 1'b0) begin bad++; $display("FAIL in_pulse: RSP_VALID got %b required 0", RSP_VALID); end
    total++; if (ar_cnt - ar0 !== 2) begin bad++; $display("FAIL in_ar_count: got %0d required 2", ar_cnt - ar0); end
    total++;
    if (ar_log.size() < ar0 + 2 || ar_log[ar0] !== 4'h8 || ar_log[ar0+1] !== 4'h0) begin
      bad++; $display("FAIL in_ar_addrs: log size %0d, required addresses 8 then 0", ar_log.size());
    end
  endtask

  task automatic test_out_poll();
    bit got; int lat; exp_t e; int st0;
    stat_seq[0] = 32'h8; stat_seq[1] = 32'h8; stat_seq[2] = 32'h0; stat_len = 3; st_base = st_cnt;
    st0 = st_cnt;
    exp_q.push_back('{1'b0, 8'h00});
    send_req(1'b1, 8'h5A);
    wait_rsp(got, lat);
    e = exp_q.pop_front();
    total++; if (!got) begin bad++; $display("FAIL out_rsp: RSP_VALID not seen, required within bound"); end
    total++; if (lat !== 9) begin bad++; $display("FAIL out_latency: got %0d required 9", lat); end
    total++; if (RSP_ERR !== e.err) begin bad++; $display("FAIL out_err: got %b required %b", RSP_ERR, e.err); end
    total++; if (st_cnt - st0 !== 3) begin bad++; $display("FAIL out_polls: got %0d required 3", st_cnt - st0); end
    total++; if (aw_addr_l !== 4'h4) begin bad++; $display("FAIL out_awaddr: got %h required 4", aw_addr_l); end
    total++; if (wdata_l !== 32'h5A) begin bad++; $display("FAIL out_wdata: got %h required 0000005a", wdata_l); end
    total++; if (wstrb_l !== 4'b0001) begin bad++; $display("FAIL out_wstrb: got %b required 0001", wstrb_l); end
    @(negedge CLK);
  endtask

  task automatic test_aw_delay();
    bit got; int lat; exp_t e; int awv0, wv0, b0;
    stat_seq[0] = 32'h0; stat_len = 1; st_base = st_cnt;
    aw_delay = 3;
    awv0 = awv_cyc; wv0 = wv_cyc; b0 = b_cnt;
    exp_q.push_back('{1'b0, 8'h00});
    send_req(1'b1, 8'h3C);
    wait_rsp(got, lat);
    e = exp_q.pop_front();
    total++; if (!got) begin bad++; $display("FAIL awd_rsp: RSP_VALID not seen, required within bound"); end
    total++; if (lat !== 8) begin bad++; $display("FAIL awd_latency: got %0d required 8", lat); end
    total++; if (RSP_ERR !== e.err) begin bad++; $display("FAIL awd_err: got %b required %b", RSP_ERR, e.err); end
    total++; if (awv_cyc - awv0 !== 4) begin bad++; $display("FAIL awd_awvalid_cycles: got %0d required 4", awv_cyc - awv0); end
    total++; if (wv_cyc - wv0 !== 1) begin bad++; $display("FAIL awd_wvalid_cycles: got %0d required 1", wv_cyc - wv0); end
    total++; if (b_cnt - b0 !== 1) begin bad++; $display("FAIL awd_b_count: got %0d required 1", b_cnt - b0); end
    total++; if (wdata_l !== 32'h3C) begin bad++; $display("FAIL awd_wdata: got %h required 0000003c", wdata_l); end
    aw_delay = 0;
    @(negedge CLK);
  endtask

  task automatic test_poll_limit();
    bit got; int lat; exp_t e; int st0, rx0;
    stat_len = 0; stat_default = 32'h0; st_base = st_cnt;
    rx_data = 32'h77;
    st0 = st_cnt; rx0 = rx_cnt;
    exp_q.push_back('{1'b1, 8'h00});
    send_req(1'b0, 8'h00);
    wait_rsp(got, lat);
    e = exp_q.pop_front();
    total++; if (!got) begin bad++; $display("FAIL plim_rsp: RSP_VALID not seen, required within bound"); end
    total++; if (lat !== 9) begin bad++; $display("FAIL plim_latency: got %0d required 9", lat); end
    total++; if (RSP_ERR !== e.err) begin bad++; $display("FAIL plim_err: got %b required %b", RSP_ERR, e.err); end
    total++; if (RSP_RDATA !== e.data) begin bad++; $display("FAIL plim_rdata: got %h required %h", RSP_RDATA, e.data); end
    total++; if (st_cnt - st0 !== 4) begin bad++; $display("FAIL plim_polls: got %0d required 4", st_cnt - st0); end
    total++; if (rx_cnt - rx0 !== 0) begin bad++; $display("FAIL plim_rx_reads: got %0d required 0", rx_cnt - rx0); end
    @(negedge CLK);
  endtask

  task automatic test_rx_err_hold();
    bit got; int lat; exp_t e; int acc0;
    stat_seq[0] = 32'h1; stat_len = 1; st_base = st_cnt;
    rx_data = 32'h41; rx_resp = 2'b10;
    acc0 = acc_cnt;
    exp_q.push_back('{1'b1, 8'h00});
    REQ_VALID = 1'b1; REQ_WRITE = 1'b0; REQ_WDATA = 8'h00;
    @(negedge CLK);
    total++; if (REQ_READY !== 1'b0 || BUSY !== 1'b1) begin
      bad++; $display("FAIL hold_busy: REQ_READY=%b BUSY=%b required 0 and 1", REQ_READY, BUSY);
    end
    wait_rsp(got, lat);
    REQ_VALID = 1'b0;
    e = exp_q.pop_front();
    total++; if (!got) begin bad++; $display("FAIL rxerr_rsp: RSP_VALID not seen, required within bound"); end
    total++; if (RSP_ERR !== e.err) begin bad++; $display("FAIL rxerr_err: got %b required %b", RSP_ERR, e.err); end
    total++; if (RSP_RDATA !== e.data) begin bad++; $display("FAIL rxerr_rdata: got %h required %h", RSP_RDATA, e.data); end
    @(negedge CLK);
    total++; if (acc_cnt - acc0 !== 1) begin bad++; $display("FAIL hold_accepts: got %0d required 1", acc_cnt - acc0); end
    rx_resp = 2'b00;
  endtask

  task automatic test_bresp_err();
    bit got; int lat; exp_t e;
    stat_seq[0] = 32'h0; stat_len = 1; st_base = st_cnt;
    b_resp = 2'b10;
    exp_q.push_back('{1'b1, 8'h00});
    send_req(1'b1, 8'hC3);
    wait_rsp(got, lat);
    e = exp_q.pop_front();
    total++; if (!got) begin bad++; $display("FAIL berr_rsp: RSP_VALID not seen, required within bound"); end
    total++; if (RSP_ERR !== e.err) begin bad++; $display("FAIL berr_err: got %b required %b", RSP_ERR, e.err); end
    b_resp = 2'b00;
    @(negedge CLK);
  endtask

  // IN then OUT with no idle gap; status words carry noise in the ignored bits.
  task automatic test_back_to_back();
    bit got; int lat; exp_t e;
    logic       wr_tab [0:1];
    logic [7:0] wd_tab [0:1];
    wr_tab[0] = 1'b0; wd_tab[0] = 8'h00;
    wr_tab[1] = 1'b1; wd_tab[1] = 8'h99;
    stat_seq[0] = 32'hFFFF_FF09; stat_seq[1] = 32'hFFFF_FFF7; stat_len = 2; st_base = st_cnt;
    rx_data = 32'hABCD_EFC3;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{1'b0, wr_tab[i] ? 8'h00 : 8'hC3});
      send_req(wr_tab[i], wd_tab[i]);
      wait_rsp(got, lat);
      e = exp_q.pop_front();
      total++; if (!got) begin bad++; $display("FAIL b2b_rsp[%0d]: RSP_VALID not seen, required within bound", i); end
      total++; if (lat !== 5) begin bad++; $display("FAIL b2b_latency[%0d]: got %0d required 5", i, lat); end
      total++; if (RSP_RDATA !== e.data || RSP_ERR !== e.err) begin
        bad++; $display("FAIL b2b_rsp_data[%0d]: got %h/%b required %h/%b", i, RSP_RDATA, RSP_ERR, e.data, e.err);
      end
      @(negedge CLK);
    end
    total++; if (wdata_l !== 32'h99) begin bad++; $display("FAIL b2b_wdata: got %h required 00000099", wdata_l); end
  endtask

  task automatic test_reset_mid();
    logic [60:0] v;
    bit got; int lat; exp_t e; int rsp0;
    ar_ready_en = 1'b0;
    send_req(1'b0, 8'h00);
    @(negedge CLK);
    total++; if (ARVALID !== 1'b1) begin bad++; $display("FAIL rmid_arvalid: got %b required 1", ARVALID); end
    #2 RST = 1'b1;
    #1;
    v = {ARVALID, ARADDR, RREADY, AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY,
         REQ_READY, RSP_VALID, RSP_ERR, RSP_RDATA, BUSY};
    total++; if (v !== 61'h0) begin bad++; $display("FAIL rmid_async_outs: got %h required 0", v); end
    ar_ready_en = 1'b1;
    @(negedge CLK);
    @(posedge CLK);
    #1 RST = 1'b0;
    rsp0 = rsp_cnt;
    repeat (6) @(negedge CLK);
    total++; if (rsp_cnt !== rsp0) begin bad++; $display("FAIL rmid_stray_rsp: got %0d pulses required 0", rsp_cnt - rsp0); end
    total++; if (REQ_READY !== 1'b1 || BUSY !== 1'b0) begin
      bad++; $display("FAIL rmid_idle: REQ_READY=%b BUSY=%b required 1 and 0", REQ_READY, BUSY);
    end
    stat_seq[0] = 32'h1; stat_len = 1; st_base = st_cnt;
    rx_data = 32'h5E;
    exp_q.push_back('{1'b0, 8'h5E});
    send_req(1'b0, 8'h00);
    wait_rsp(got, lat);
    e = exp_q.pop_front();
    total++; if (!got || RSP_RDATA !== e.data || lat !== 5) begin
      bad++; $display("FAIL rmid_recover: got seen=%b data=%h lat=%0d required 1 %h 5", got, RSP_RDATA, lat, e.data);
    end
    @(negedge CLK);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    @(posedge CLK);
    #1 RST = 1'b0;
    test_reset();
    test_in();
    test_out_poll();
    test_aw_delay();
    test_poll_limit();
    test_rx_err_hold();
    test_bresp_err();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_io_ctrl.md
Name: core_io_ctrl

Overview:
Sequencer for the core's IN/OUT instructions over the AXI4-Lite UART-Lite port.
- Accepts one byte-read or byte-write request at a time from the core.
- Polls the UART status register until RX data is present (IN) or the TX FIFO is not full (OUT).
- Performs the data access and returns a one-cycle response.
- BUSY drives the core's stall ("stole") so the core's MEMORY stage holds until the access completes.

Parameters:
POLL_LIMIT, 0, maximum status polls per request before aborting with error; 0 = poll forever
RX_ADDR, 4'h0, UART RX FIFO register offset
TX_ADDR, 4'h4, UART TX FIFO register offset
STAT_ADDR, 4'h8, UART status register offset

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
REQ_VALID  in  1  core requests an IO access
REQ_WRITE  in  1  1 = OUT (write byte), 0 = IN (read byte)
REQ_WDATA  in  8  byte to transmit for OUT
REQ_READY  out  1  request accepted this cycle (high only in IDLE)
RSP_VALID  out  1  one-cycle completion pulse
RSP_RDATA  out  8  received byte, valid with RSP_VALID for IN
RSP_ERR  out  1  with RSP_VALID: bus error or poll limit hit
BUSY  out  1  request in flight (accepted, RSP_VALID not yet pulsed)
ARADDR out 4 / ARVALID out 1 / ARREADY in 1  AXI-Lite read address channel
RDATA in 32 / RRESP in 2 / RVALID in 1 / RREADY out 1  AXI-Lite read data channel
AWADDR out 4 / AWVALID out 1 / AWREADY in 1  AXI-Lite write address channel
WDATA out 32 / WSTRB out 4 / WVALID out 1 / WREADY in 1  AXI-Lite write data channel
BRESP in 2 / BVALID in 1 / BREADY out 1  AXI-Lite write response channel

Behaviour:
- Reset (async, immediate): state IDLE, poll count 0. All VALID/READY outputs 0, addresses 0, WDATA 0, WSTRB 0. RSP_VALID, RSP_ERR, RSP_RDATA 0; BUSY 0. A reset mid-transaction abandons it; no completion is generated.
- States: IDLE, STAT_AR, STAT_R, RX_AR, RX_R, TX_AWW, TX_B, RESP.
- IDLE:
  - REQ_READY=1.
  - On REQ_VALID: latch REQ_WRITE and REQ_WDATA, clear poll count, go to STAT_AR.
- STAT_AR:
  - ARADDR=STAT_ADDR, ARVALID=1 held until ARVALID&ARREADY.
  - On handshake: ARVALID=0, go to STAT_R.
- STAT_R:
  - RREADY=1 until RVALID&RREADY; increment poll count on handshake.
  - If RRESP!=0: error, go to RESP.
  - IN: RDATA[0]=1 -> RX_AR; otherwise re-poll (STAT_AR).
  - OUT: RDATA[3]=0 -> TX_AWW; otherwise re-poll (STAT_AR).
  - Re-poll when poll count == POLL_LIMIT (POLL_LIMIT != 0): error, go to RESP.
- RX_AR / RX_R:
  - Same handshake as STAT_AR / STAT_R with ARADDR=RX_ADDR.
  - Capture RDATA[7:0] into RSP_RDATA; RRESP!=0 -> error. Go to RESP.
- TX_AWW:
  - AWADDR=TX_ADDR, WDATA={24'b0, byte}, WSTRB=4'b0001.
  - AWVALID and WVALID asserted together; each drops independently on its own handshake, including the same cycle.
  - Go to TX_B when both handshakes are done.
- TX_B:
  - BREADY=1 until BVALID&BREADY.
  - BRESP!=0 -> error. Go to RESP.
- RESP:
  - RSP_VALID=1 for exactly one cycle; RSP_ERR as flagged.
  - On error, RSP_RDATA=0.
  - Next state IDLE.
- REQ_VALID during any non-IDLE state is ignored.
- BUSY = (state != IDLE) && (state != RESP).
- Response latency with an always-ready slave that returns R/B one cycle after address handshake:
  - IN, RX ready on first poll: RSP_VALID 5 cycles after acceptance.
  - OUT, TX not full: 5 cycles after acceptance.
  - Each extra poll adds 2 cycles.
- Poll counter saturates; width clog2(POLL_LIMIT+1), minimum 1 bit.
- RDATA bits other than [7:0], [3] and [0] are ignored.

Decomposition:
- Package core_io_pkg holds:
  - state enum io_state_t;
  - status bit indices STAT_RX_VALID=0, STAT_TX_FULL=3;
  - AXI response code RESP_OKAY=2'b00;
  - default register offsets.
- Single module; no sub-module needed.

Test Plan:
- IN, status returns 32'h1, RX returns 32'h41 -> RSP_VALID once, RSP_RDATA=8'h41, RSP_ERR=0, exactly 2 AR handshakes (ARADDR 8 then 0).
- OUT 8'h5A, status 32'h8 twice then 32'h0 -> 3 status polls, then one write: AWADDR=4, WDATA=32'h5A, WSTRB=4'b0001; RSP_VALID with RSP_ERR=0.
- AWREADY delayed 3 cycles while WREADY is immediate -> WVALID drops after 1 cycle, AWVALID holds 4 cycles, single BREADY handshake, completion follows.
- POLL_LIMIT=4, IN with status always 32'h0 -> exactly 4 status reads, then RSP_VALID with RSP_ERR=1 and RSP_RDATA=0.
- RRESP=2'b10 on RX read -> RSP_ERR=1, RSP_RDATA=0; REQ_VALID held high during the transaction is not accepted until IDLE.
- Assert RST while ARVALID=1 -> all outputs 0 immediately (asynchronous); after release, REQ_READY=1 and no stray RSP_VALID.
